// File: rtl/lynx_crtc.sv
// lynx_crtc: 6845-subset CRT controller feeding the pixel shifter.
// Generates display enable, H/V sync, 14-bit character address and the
// scanline within the character row. All timing comes from CPU-written registers.
//
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-low
//   ce     - pixel clock enable (8 per character)
//   cs/rs/wr/di - CPU register port (rs=0 address latch, rs=1 data)
//   de, hsync, vsync, ma[13:0], ra[4:0], cursor - registered video timing outputs
//
// Build option: define CRTC_CURSOR_EN to add the cursor registers
// (R10, R11, R14, R15) and blink logic; otherwise cursor is tied low.
module lynx_crtc (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        cs,
  input  logic        rs,
  input  logic        wr,
  input  logic [7:0]  di,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [13:0] ma,
  output logic [4:0]  ra,
  output logic        cursor
);

  localparam int unsigned HC_W  = 8;
  localparam int unsigned MA_W  = 14;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned ROW_W = 7;
  localparam int unsigned VS_W  = 5;

  // Programmable registers
  logic [7:0]       r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, r13_q, r13_d;
  logic [ROW_W-1:0] r4_q, r4_d, r6_q, r6_d, r7_q, r7_d;
  logic [RA_W-1:0]  r5_q, r5_d, r9_q, r9_d;
  logic [5:0]       r12_q, r12_d;
  logic [4:0]       addr_q, addr_d;

  // Timing counters
  logic [2:0]       phase_q, phase_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [RA_W-1:0]  ra_cnt_q, ra_cnt_d;
  logic [ROW_W-1:0] vrow_q, vrow_d;
  logic [MA_W-1:0]  rowstart_q, rowstart_d;
  logic             adjust_q, adjust_d;
  logic             vs_run_q, vs_run_d;
  logic [VS_W-1:0]  vs_idx_q, vs_idx_d;

  // Output flops
  logic             de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic [MA_W-1:0]  ma_q, ma_d;
  logic [RA_W-1:0]  ra_o_q, ra_o_d;

  logic             ctick, line_end, frame_end, vs_start;
  logic [4:0]       hw, vw;
  logic             de_c, hsync_c, vsync_c;
  logic [MA_W-1:0]  ma_c;

`ifdef CRTC_CURSOR_EN
  logic [6:0]       r10_q, r10_d;
  logic [4:0]       r11_q, r11_d;
  logic [5:0]       r14_q, r14_d;
  logic [7:0]       r15_q, r15_d;
  logic [4:0]       frame_q, frame_d;
  logic             cursor_q, cursor_d;
  logic             blink_on_c, cursor_c;
`endif

  // CPU register port: address latch and data writes
  always_comb begin
    addr_d = addr_q;
    r0_d = r0_q; r1_d = r1_q; r2_d = r2_q; r3_d = r3_q;
    r4_d = r4_q; r5_d = r5_q; r6_d = r6_q; r7_d = r7_q;
    r9_d = r9_q; r12_d = r12_q; r13_d = r13_q;
`ifdef CRTC_CURSOR_EN
    r10_d = r10_q; r11_d = r11_q; r14_d = r14_q; r15_d = r15_q;
`endif
    if (cs && wr) begin
      if (!rs) begin
        addr_d = di[4:0];
      end else begin
        case (addr_q)
          5'd0:  r0_d  = di;
          5'd1:  r1_d  = di;
          5'd2:  r2_d  = di;
          5'd3:  r3_d  = di;
          5'd4:  r4_d  = di[6:0];
          5'd5:  r5_d  = di[4:0];
          5'd6:  r6_d  = di[6:0];
          5'd7:  r7_d  = di[6:0];
          5'd9:  r9_d  = di[4:0];
`ifdef CRTC_CURSOR_EN
          5'd10: r10_d = di[6:0];
          5'd11: r11_d = di[4:0];
          5'd14: r14_d = di[5:0];
          5'd15: r15_d = di;
`endif
          5'd12: r12_d = di[5:0];
          5'd13: r13_d = di;
          default: ;
        endcase
      end
    end
  end

  assign ctick    = ce && (phase_q == 3'd7);
  assign line_end = ctick && (hc_q == r0_q);
  assign vs_start = (vrow_q == r7_q) && (ra_cnt_q == '0) && !adjust_q;
  // Sync widths: a zero field means 16
  assign hw = (r3_q[3:0] == 4'd0) ? 5'd16 : {1'b0, r3_q[3:0]};
  assign vw = (r3_q[7:4] == 4'd0) ? 5'd16 : {1'b0, r3_q[7:4]};

  // Character, line, row and frame sequencing
  always_comb begin
    phase_d    = phase_q;
    hc_d       = hc_q;
    ra_cnt_d   = ra_cnt_q;
    vrow_d     = vrow_q;
    rowstart_d = rowstart_q;
    adjust_d   = adjust_q;
    vs_run_d   = vs_run_q;
    vs_idx_d   = vs_idx_q;
    frame_end  = 1'b0;
    if (ce) phase_d = phase_q + 3'd1;
    // Equality-only compare: an R0 below hc lets hc wrap through 255
    if (ctick) hc_d = line_end ? '0 : hc_q + 8'd1;
    if (line_end) begin
      if (adjust_q) begin
        if (ra_cnt_q == r5_q - 5'd1) frame_end = 1'b1;
        else                         ra_cnt_d  = ra_cnt_q + 5'd1;
      end else if (ra_cnt_q != r9_q) begin
        ra_cnt_d = ra_cnt_q + 5'd1;
      end else if (vrow_q != r4_q) begin
        ra_cnt_d   = '0;
        vrow_d     = vrow_q + 7'd1;
        rowstart_d = rowstart_q + MA_W'(r1_q);
      end else if (r5_q != '0) begin
        ra_cnt_d = '0;
        adjust_d = 1'b1;
      end else begin
        frame_end = 1'b1;
      end
      if (frame_end) begin
        ra_cnt_d   = '0;
        vrow_d     = '0;
        adjust_d   = 1'b0;
        rowstart_d = {r12_q, r13_q};
      end
      // Vsync line counter: the start line is index 0, later lines count up to VW
      if (vs_start) begin
        vs_run_d = 1'b1;
        vs_idx_d = 5'd1;
      end else if (vs_run_q) begin
        vs_idx_d = vs_idx_q + 5'd1;
        if (vs_idx_d >= vw) vs_run_d = 1'b0;
      end
    end
  end

  // Output equations from the pre-update counters, captured on ctick
  always_comb begin
    ma_c    = rowstart_q + MA_W'(hc_q);
    de_c    = (hc_q < r1_q) && (vrow_q <= r6_q - 7'd1) && !adjust_q;
    hsync_c = (hc_q >= r2_q) && ({1'b0, hc_q} < {1'b0, r2_q} + {4'b0, hw});
    vsync_c = vs_start || (vs_run_q && (vs_idx_q < vw));
    de_d    = ctick ? de_c     : de_q;
    ma_d    = ctick ? ma_c     : ma_q;
    ra_o_d  = ctick ? ra_cnt_q : ra_o_q;
    hsync_d = ctick ? hsync_c  : hsync_q;
    vsync_d = ctick ? vsync_c  : vsync_q;
  end

`ifdef CRTC_CURSOR_EN
  // Cursor: address/scanline window gated by mode (on, off, blink /16, /32)
  always_comb begin
    case (r10_q[6:5])
      2'b00:   blink_on_c = 1'b1;
      2'b01:   blink_on_c = 1'b0;
      2'b10:   blink_on_c = frame_q[3];
      default: blink_on_c = frame_q[4];
    endcase
    cursor_c = de_c && (ma_c == {r14_q, r15_q}) && (ra_cnt_q >= r10_q[4:0]) &&
               (ra_cnt_q <= r11_q) && blink_on_c;
    cursor_d = ctick ? cursor_c : cursor_q;
    frame_d  = frame_end ? frame_q + 5'd1 : frame_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r10_q <= '0; r11_q <= '0; r14_q <= '0; r15_q <= '0;
      frame_q <= '0; cursor_q <= 1'b0;
    end else begin
      r10_q <= r10_d; r11_q <= r11_d; r14_q <= r14_d; r15_q <= r15_d;
      frame_q <= frame_d; cursor_q <= cursor_d;
    end
  end

  assign cursor = cursor_q;
`else
  assign cursor = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r0_q <= 8'd69; r1_q <= 8'd32; r2_q <= 8'd47; r3_q <= 8'h37;
      r4_q <= 7'd38; r5_q <= 5'd0;  r6_q <= 7'd31; r7_q <= 7'd34;
      r9_q <= 5'd7;  r12_q <= '0;   r13_q <= '0;   addr_q <= '0;
      phase_q <= '0; hc_q <= '0; ra_cnt_q <= '0; vrow_q <= '0;
      rowstart_q <= '0; adjust_q <= 1'b0; vs_run_q <= 1'b0; vs_idx_q <= '0;
      de_q <= 1'b0; hsync_q <= 1'b0; vsync_q <= 1'b0; ma_q <= '0; ra_o_q <= '0;
    end else begin
      r0_q <= r0_d; r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d;
      r4_q <= r4_d; r5_q <= r5_d; r6_q <= r6_d; r7_q <= r7_d;
      r9_q <= r9_d; r12_q <= r12_d; r13_q <= r13_d; addr_q <= addr_d;
      phase_q <= phase_d; hc_q <= hc_d; ra_cnt_q <= ra_cnt_d; vrow_q <= vrow_d;
      rowstart_q <= rowstart_d; adjust_q <= adjust_d;
      vs_run_q <= vs_run_d; vs_idx_q <= vs_idx_d;
      de_q <= de_d; hsync_q <= hsync_d; vsync_q <= vsync_d; ma_q <= ma_d; ra_o_q <= ra_o_d;
    end
  end

  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign ma    = ma_q;
  assign ra    = ra_o_q;

endmodule

// File: tb/tb_lynx_crtc.sv
// Testbench for lynx_crtc: directed register/reset scenarios plus randomized
// geometries and pixel-enable patterns, checked against a frame-arithmetic model.
module tb_lynx_crtc;

  logic        clock, reset, ce, cs, rs, wr;
  logic [7:0]  di;
  logic        de, hsync, vsync, cursor;
  logic [13:0] ma;
  logic [4:0]  ra;

  int passed, total;
  int ce_cnt;
  bit tick;
  int cur_n;
  int m_r0, m_r1, m_r2, m_r3, m_r4, m_r5, m_r6, m_r7, m_r9;
  int m_r10, m_r11, m_r12, m_r13, m_r14, m_r15;

  lynx_crtc dut (
    .clock(clock), .reset(reset), .ce(ce), .cs(cs), .rs(rs), .wr(wr), .di(di),
    .de(de), .hsync(hsync), .vsync(vsync), .ma(ma), .ra(ra), .cursor(cursor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s char=%0d got %0h expected %0h", tag, cur_n, got, exp);
  endtask

  // One clock; sample #1 after the edge and note whether a character tick occurred
  task automatic cyc();
    @(posedge clock);
    #1;
    if (ce) ce_cnt++;
    tick = ce && (ce_cnt % 8 == 0);
  endtask

  task automatic wreg(input int a, input int d);
    cs = 1'b1; wr = 1'b1; rs = 1'b0; di = 8'(a);
    cyc();
    rs = 1'b1; di = 8'(d);
    cyc();
    cs = 1'b0; wr = 1'b0; rs = 1'b0; di = 8'h00;
  endtask

  task automatic defaults_model();
    m_r0 = 69; m_r1 = 32; m_r2 = 47; m_r3 = 8'h37; m_r4 = 38; m_r5 = 0;
    m_r6 = 31; m_r7 = 34; m_r9 = 7; m_r12 = 0; m_r13 = 0;
    m_r10 = 0; m_r11 = 0; m_r14 = 0; m_r15 = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_hsync"}, 32'(hsync), 0);
    chk({tag, "_vsync"}, 32'(vsync), 0);
    chk({tag, "_ma"}, 32'(ma), 0);
    chk({tag, "_ra"}, 32'(ra), 0);
    chk({tag, "_cursor"}, 32'(cursor), 0);
  endtask

  // Expected outputs for the n-th character since the counters last restarted
  function automatic void model(input int n, output bit e_de, output bit e_hs,
                                output bit e_vs, output bit e_cur,
                                output int e_ma, output int e_ra);
    int L, lpr, dl, F, g, h, f, l, row, st, hw, vw, s;
    bit adj;
    L   = m_r0 + 1;
    lpr = m_r9 + 1;
    dl  = (m_r4 + 1) * lpr;
    F   = dl + m_r5;
    g   = n / L;
    h   = n % L;
    f   = g / F;
    l   = g % F;
    adj = (l >= dl);
    row = adj ? m_r4 : l / lpr;
    e_ra = adj ? l - dl : l % lpr;
    st  = (f == 0) ? 0 : m_r12 * 256 + m_r13;
    e_ma = (st + row * m_r1 + h) % 16384;
    e_de = (h < m_r1) && (row <= ((m_r6 + 127) % 128)) && !adj;
    hw  = (m_r3 % 16 == 0) ? 16 : m_r3 % 16;
    vw  = (m_r3 / 16 == 0) ? 16 : m_r3 / 16;
    e_hs = (h >= m_r2) && (h < m_r2 + hw);
    s   = m_r7 * lpr;
    e_vs = (g >= s) && (((g - s) % F) < vw);
    e_cur = 1'b0;
`ifdef CRTC_CURSOR_EN
    begin
      int mode;
      bit on;
      mode = (m_r10 / 32) % 4;
      on = (mode == 0) || (mode == 2 && ((f / 8) % 2 == 1)) || (mode == 3 && ((f / 16) % 2 == 1));
      e_cur = e_de && (e_ma == m_r14 * 256 + m_r15) && (e_ra >= m_r10 % 32) &&
              (e_ra <= m_r11) && on;
    end
`endif
  endfunction

  task automatic check_tick();
    bit e_de, e_hs, e_vs, e_cur;
    int e_ma, e_ra;
    cur_n = ce_cnt / 8 - 1;
    model(cur_n, e_de, e_hs, e_vs, e_cur, e_ma, e_ra);
    chk("de", 32'(de), 32'(e_de));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("ma", 32'(ma), e_ma);
    chk("ra", 32'(ra), e_ra);
    chk("cursor", 32'(cursor), 32'(e_cur));
  endtask

  task automatic run_check(input int nticks, input bit rnd_ce);
    int target, guard;
    target = ce_cnt / 8 + nticks;
    guard = 0;
    while (ce_cnt / 8 < target && guard < nticks * 80) begin
      ce = rnd_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc();
      guard++;
      if (tick) check_tick();
    end
    if (ce_cnt / 8 < target) begin
      total++;
      $error("FAIL run_timeout got %0d ticks expected %0d", ce_cnt / 8, target);
    end
  endtask

  task automatic adv_to(input int target);
    int guard;
    guard = 0;
    ce = 1'b1;
    while (ce_cnt / 8 < target && guard < 20000) begin
      cyc();
      guard++;
    end
    cur_n = ce_cnt / 8 - 1;
  endtask

  task automatic do_reset();
    ce = 1'b0;
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    ce_cnt = 0;
  endtask

  initial begin
    passed = 0; total = 0; ce_cnt = 0; cur_n = 0;
    reset = 1'b0; ce = 1'b0; cs = 1'b0; rs = 1'b0; wr = 1'b0; di = 8'h00;

    // Reset state
    do_reset();
    check_zero("reset");

    // Defaults from reset, then R0 written below the running hc
    defaults_model();
    run_check(20, 1'b0);
    wreg(0, 10);
    adv_to(256);
    chk("wrap_ma255", 32'(ma), 255);
    chk("wrap_de255", 32'(de), 0);
    chk("wrap_ra255", 32'(ra), 0);
    adv_to(257);
    chk("wrap_ma0", 32'(ma), 0);
    chk("wrap_ra0", 32'(ra), 0);
    adv_to(267);
    chk("short_ma10", 32'(ma), 10);
    adv_to(268);
    chk("short_l1_ma", 32'(ma), 0);
    chk("short_l1_ra", 32'(ra), 1);
    adv_to(279);
    chk("short_l2_ma", 32'(ma), 0);
    chk("short_l2_ra", 32'(ra), 2);

    // One-clock reset mid-line
    adv_to(282);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check_zero("midreset");
    reset = 1'b1;
    ce_cnt = 0;
    defaults_model();
    run_check(160, 1'b0);

    // Randomized geometries with random pixel-enable gaps
    for (int rnd = 0; rnd < 6; rnd++) begin
      int L, F, cstart;
      do_reset();
      m_r0  = $urandom_range(8, 15);
      m_r1  = $urandom_range(1, m_r0);
      m_r2  = $urandom_range(0, m_r0);
      m_r3  = $urandom_range(0, 255);
      m_r9  = $urandom_range(0, 2);
      m_r4  = $urandom_range(1, 4);
      m_r5  = (rnd == 0) ? 2 : $urandom_range(0, 2);
      m_r6  = $urandom_range(0, 7);
      m_r7  = $urandom_range(0, m_r4);
      m_r12 = $urandom_range(0, 63);
      m_r13 = $urandom_range(0, 255);
      cstart = $urandom_range(0, m_r9);
      m_r10 = cstart + 32 * $urandom_range(0, 1);
      m_r11 = $urandom_range(cstart, 4);
      m_r14 = 0;
      m_r15 = $urandom_range(0, m_r0);
      wreg(0, m_r0);  wreg(1, m_r1);  wreg(2, m_r2);  wreg(3, m_r3);
      wreg(4, m_r4);  wreg(5, m_r5);  wreg(6, m_r6);  wreg(7, m_r7);
      wreg(9, m_r9);  wreg(12, m_r12); wreg(13, m_r13);
      wreg(10, m_r10); wreg(11, m_r11); wreg(14, m_r14); wreg(15, m_r15);
      wreg($urandom_range(16, 31), $urandom_range(0, 255));
      L = m_r0 + 1;
      F = (m_r4 + 1) * (m_r9 + 1) + m_r5;
      run_check(2 * F * L + 2 * L, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
